// File: rtl/x_ramd16_fifo_ctrl.sv
// FWFT FIFO sequencer for 16x1 dual-port RAM cells; write-to-RD_VALID 2 edges, 17-word capacity, WR_READY drops at full.
// Optional registered ALMOST_FULL under XRAMD16_FIFO_ALMOST_FULL_EN; otherwise ALMOST_FULL is tied low.
module x_ramd16_fifo_ctrl #(
  parameter int WIDTH     = 1,
  parameter int AF_THRESH = 14
) (
  input  logic             CLK,
  input  logic             RST_B,
  input  logic             WR_VALID,
  output logic             WR_READY,
  input  logic [WIDTH-1:0] DIN,
  output logic             RD_VALID,
  input  logic             RD_READY,
  output logic [WIDTH-1:0] DOUT,
  output logic [WIDTH-1:0] RAM_I,
  output logic             RAM_WE,
  output logic [3:0]       RAM_WADR,
  output logic [3:0]       RAM_RADR,
  input  logic [WIDTH-1:0] RAM_O,
  output logic             ALMOST_FULL
);

  if (AF_THRESH < 0 || AF_THRESH > 16) begin : g_bad_thresh
    $error("AF_THRESH out of range");
  end

  logic [3:0]       r_wptr;
  logic [3:0]       r_rptr;
  logic [4:0]       r_cnt;
  logic             r_ovld;
  logic [WIDTH-1:0] r_dout;

  logic             w_wf;
  logic             w_ld;
  logic             w_pop_only;
  logic [4:0]       w_cnt_nxt;

  assign WR_READY   = RST_B && (r_cnt != 5'd16);
  assign w_wf       = WR_VALID && WR_READY;
  // ld needs cnt>0, so rptr never catches wptr on the cycle it is read.
  assign w_ld       = (r_cnt != 5'd0) && (!r_ovld || RD_READY);
  assign w_pop_only = r_ovld && RD_READY && (r_cnt == 5'd0);
  assign w_cnt_nxt  = r_cnt + {4'd0, w_wf} - {4'd0, w_ld};

  assign RAM_I    = DIN;
  assign RAM_WE   = w_wf;
  assign RAM_WADR = r_wptr;
  assign RAM_RADR = r_rptr;
  assign RD_VALID = r_ovld;
  assign DOUT     = r_dout;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_wptr <= 4'd0;
      r_rptr <= 4'd0;
      r_cnt  <= 5'd0;
      r_ovld <= 1'b0;
      r_dout <= '0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_wf) begin
        r_wptr <= r_wptr + 4'd1;
      end
      if (w_ld) begin
        r_dout <= RAM_O;
        r_ovld <= 1'b1;
        r_rptr <= r_rptr + 4'd1;
      end else if (w_pop_only) begin
        r_ovld <= 1'b0;
      end
    end
  end

`ifdef XRAMD16_FIFO_ALMOST_FULL_EN
  localparam logic [5:0] AF_T = AF_THRESH[5:0];
  logic r_af;

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      r_af <= 1'b0;
    end else begin
      r_af <= ({1'b0, w_cnt_nxt} >= AF_T);
    end
  end

  assign ALMOST_FULL = r_af;
`else
  assign ALMOST_FULL = 1'b0;
`endif

endmodule

// File: tb/tb_x_ramd16_fifo_ctrl.sv
// Bench for x_ramd16_fifo_ctrl: behavioural RAM cells plus a queue-based FIFO reference model.
module tb_x_ramd16_fifo_ctrl;
  localparam int WIDTH     = 8;
  localparam int AF_THRESH = 14;

  logic             CLK;
  logic             RST_B;
  logic             WR_VALID;
  logic             WR_READY;
  logic [WIDTH-1:0] DIN;
  logic             RD_VALID;
  logic             RD_READY;
  logic [WIDTH-1:0] DOUT;
  logic [WIDTH-1:0] RAM_I;
  logic             RAM_WE;
  logic [3:0]       RAM_WADR;
  logic [3:0]       RAM_RADR;
  logic [WIDTH-1:0] RAM_O;
  logic             ALMOST_FULL;

  x_ramd16_fifo_ctrl #(.WIDTH(WIDTH), .AF_THRESH(AF_THRESH)) dut (
    .CLK(CLK), .RST_B(RST_B), .WR_VALID(WR_VALID), .WR_READY(WR_READY), .DIN(DIN),
    .RD_VALID(RD_VALID), .RD_READY(RD_READY), .DOUT(DOUT), .RAM_I(RAM_I), .RAM_WE(RAM_WE),
    .RAM_WADR(RAM_WADR), .RAM_RADR(RAM_RADR), .RAM_O(RAM_O), .ALMOST_FULL(ALMOST_FULL)
  );

  // External RAM cells: synchronous write, asynchronous read.
  logic [WIDTH-1:0] mem [16];
  always @(posedge CLK) if (RAM_WE) mem[RAM_WADR] <= RAM_I;
  assign RAM_O = mem[RAM_RADR];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: RAM-resident words as a queue plus the output holding word.
  logic [WIDTH-1:0] mq[$];
  bit               m_ovld;
  logic [WIDTH-1:0] m_dout;
  int               m_wn;
  int               m_rn;
  bit               m_af;

  task automatic model_reset();
    mq.delete();
    m_ovld = 0; m_dout = '0; m_wn = 0; m_rn = 0; m_af = 0;
  endtask

  task automatic check_all(input string ph);
    bit exp_rdy;
    exp_rdy = RST_B && (mq.size() != 16);
    check_eq({ph, ":wr_ready"}, 32'(WR_READY), 32'(exp_rdy));
    check_eq({ph, ":ram_we"},   32'(RAM_WE),   32'(WR_VALID && exp_rdy));
    check_eq({ph, ":wadr"},     32'(RAM_WADR), 32'(m_wn % 16));
    check_eq({ph, ":radr"},     32'(RAM_RADR), 32'(m_rn % 16));
    check_eq({ph, ":ram_i"},    32'(RAM_I),    32'(DIN));
    check_eq({ph, ":rd_valid"}, 32'(RD_VALID), 32'(m_ovld));
    check_eq({ph, ":dout"},     32'(DOUT),     32'(m_dout));
    check_eq({ph, ":af"},       32'(ALMOST_FULL), 32'(m_af));
  endtask

  task automatic cycle(input string ph, input bit wv, input logic [WIDTH-1:0] d, input bit rr);
    bit wr, ld;
    @(negedge CLK);
    WR_VALID = wv; DIN = d; RD_READY = rr;
    #1;
    check_all(ph);
    wr = wv && (mq.size() < 16);
    ld = (mq.size() > 0) && (!m_ovld || rr);
    @(posedge CLK);
    if (ld) begin
      m_dout = mq.pop_front();
      m_ovld = 1;
      m_rn++;
    end else if (m_ovld && rr) begin
      m_ovld = 0;
    end
    if (wr) begin
      mq.push_back(d);
      m_wn++;
    end
`ifdef XRAMD16_FIFO_ALMOST_FULL_EN
    m_af = (mq.size() >= AF_THRESH);
`else
    m_af = 0;
`endif
  endtask

  initial begin
    RST_B = 1'b0; WR_VALID = 1'b0; DIN = '0; RD_READY = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge CLK);
    RST_B = 1'b1;

    // Single write, then observe fall-through.
    cycle("single", 1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 3; i++) cycle("single", 1'b0, 8'd0, 1'b0);
    cycle("single", 1'b0, 8'd0, 1'b1);

    // Fill to 17 words, then an 18th attempt.
    for (int i = 0; i < 17; i++) cycle("fill", 1'b1, 8'(8'h20 + i), 1'b0);
    cycle("full", 1'b1, 8'hEE, 1'b0);
    check_eq("full_cnt_model", 32'(mq.size()), 32'd16);

    // Drain everything and a few extra reads.
    for (int i = 0; i < 20; i++) cycle("drain", 1'b0, 8'd0, 1'b1);

    // Streaming with wrap-around.
    for (int i = 0; i < 40; i++) cycle("stream", 1'b1, 8'(8'h40 + i), 1'b1);
    for (int i = 0; i < 3; i++) cycle("stream", 1'b0, 8'd0, 1'b1);

    // Hold 5 words, then asynchronous reset between edges.
    for (int i = 0; i < 5; i++) cycle("hold", 1'b1, 8'(8'h90 + i), 1'b0);
    #2;
    RST_B = 1'b0;
    #1;
    model_reset();
    check_eq("arst:rd_valid", 32'(RD_VALID), 32'd0);
    check_eq("arst:wr_ready", 32'(WR_READY), 32'd0);
    check_eq("arst:af",       32'(ALMOST_FULL), 32'd0);
    check_eq("arst:ram_we",   32'(RAM_WE), 32'd0);
    WR_VALID = 1'b0;
    @(negedge CLK);
    RST_B = 1'b1;
    cycle("post_rst", 1'b1, 8'hA5, 1'b0);
    cycle("post_rst", 1'b0, 8'd0, 1'b0);
    cycle("post_rst", 1'b0, 8'd0, 1'b1);
    cycle("post_rst", 1'b0, 8'd0, 1'b0);

    // Almost-full threshold: 15 writes leave 14 in RAM; one read drops to 13.
    for (int i = 0; i < 15; i++) cycle("af", 1'b1, 8'(8'hC0 + i), 1'b0);
    cycle("af", 1'b0, 8'd0, 1'b1);
    for (int i = 0; i < 2; i++) cycle("af", 1'b0, 8'd0, 1'b0);
    for (int i = 0; i < 20; i++) cycle("af_drain", 1'b0, 8'd0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      bit wv, rr;
      wv = ($urandom_range(0, 3) != 0);
      rr = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      cycle("rand", wv, 8'($urandom), rr);
    end
    for (int i = 0; i < 20; i++) cycle("rand_drain", 1'b0, 8'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
